pack_s3_ctrl: RTL and testbench

- Packs a stream of trits (one S3 polynomial of N_COEFF coefficients) into bytes, five trits per byte: byte = t0 + 3·t1 + 9·t2 + 27·t3 + 81·t4, so every byte is in 0..242.
- Sequences a multi-cycle 5-trit-to-byte accumulator: one load cycle, then four add cycles.
- Buffers the next trit group while the current one converts.
- Sits between the polynomial coefficient stream and the byte-oriented ciphertext/key output buffer.

---
 rtl/pack_s3_pkg.sv | 23 ++
 rtl/trit5_acc.sv | 57 +++++
 rtl/pack_s3_ctrl.sv | 127 ++++++++++++
 tb/tb_pack_s3_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_s3_pkg.sv
// Shared definitions for the S3 trit-to-byte packer.
// Trit encodings, powers of three, converter states.
package pack_s3_pkg;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_ILL = 2'b11;

  localparam int unsigned POW3 [5] = '{1, 3, 9, 27, 81};

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_LOAD,
    CV_ADD,
    CV_HOLD
  } cv_state_t;

  function automatic int nbytes(input int n);
    return (n + 4) / 5;
  endfunction

endpackage

// File: rtl/trit5_acc.sv
// Five-trit converter register with a shift/add accumulator.
// One load cycle (t4*81) followed by four add cycles.
module trit5_acc
  import pack_s3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       copy,
  input  logic [9:0] grp,
  input  logic       load,
  input  logic       add,
  output logic [7:0] acc,
  output logic       last_step
);

  logic [9:0] grp_q;
  logic [1:0] step;
  logic [7:0] t0, t1, t2, t3, t4;
  logic [7:0] term;

  assign t0 = {6'd0, grp_q[1:0]};
  assign t1 = {6'd0, grp_q[3:2]};
  assign t2 = {6'd0, grp_q[5:4]};
  assign t3 = {6'd0, grp_q[7:6]};
  assign t4 = {6'd0, grp_q[9:8]};

  // step 0..3 adds t3*27, t2*9, t1*3, t0
  always_comb begin
    term = 8'd0;
    case (step)
      2'd0: term = (t3 << 4) + (t3 << 3) + (t3 << 1) + t3;
      2'd1: term = (t2 << 3) + t2;
      2'd2: term = (t1 << 1) + t1;
      default: term = t0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q <= 10'd0;
      acc   <= 8'd0;
      step  <= 2'd0;
    end else begin
      if (copy) grp_q <= grp;
      if (load) begin
        acc  <= (t4 << 6) + (t4 << 4) + t4;
        step <= 2'd0;
      end else if (add) begin
        acc  <= acc + term;
        step <= step + 2'd1;
      end
    end
  end

  assign last_step = (step == 2'd3);

endmodule

// File: rtl/pack_s3_ctrl.sv
// Packs a stream of trits into bytes, five trits per byte.
// Owns the collector, counters, handshakes and converter FSM.
module pack_s3_ctrl
  import pack_s3_pkg::*;
#(
  parameter int N_COEFF = 700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  input  logic [1:0] in_trit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err_trit
);

  localparam int NB = nbytes(N_COEFF);
  localparam int CW = $clog2(N_COEFF + 1);
  localparam int BW = $clog2(NB + 1);
  localparam logic [CW-1:0] N_END  = CW'(N_COEFF);
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

  cv_state_t     state, state_n;
  logic [CW-1:0] trit_cnt;
  logic [2:0]    slot;
  logic [BW-1:0] byte_cnt;
  logic [9:0]    col;
  logic [1:0]    tv;
  logic          take_start, take_trit, full;
  logic          last_byte, hs, copy;
  logic          acc_load, acc_add, last_step;
  logic [7:0]    acc;

  assign take_start = start & ~busy;
  assign full = (slot == 3'd5) |
                ((trit_cnt == N_END) & (slot != 3'd0));
  assign in_ready  = busy & ~full & (trit_cnt != N_END);
  assign take_trit = in_valid & in_ready;
  assign tv = (in_trit == TRIT_ILL) ? TRIT_0 : in_trit;
  assign last_byte = (byte_cnt == B_LAST);
  assign hs = (state == CV_HOLD) & out_ready;

  // Hand-off from collector to converter, also straight out of HOLD
  assign copy = full &
                ((state == CV_IDLE) | (hs & ~last_byte));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CV_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CV_IDLE: if (copy) state_n = CV_LOAD;
      CV_LOAD: state_n = CV_ADD;
      CV_ADD:  if (last_step) state_n = CV_HOLD;
      CV_HOLD: if (out_ready) state_n = copy ? CV_LOAD : CV_IDLE;
      default: state_n = CV_IDLE;
    endcase
  end

  always_comb begin
    acc_load  = (state == CV_LOAD);
    acc_add   = (state == CV_ADD);
    out_valid = (state == CV_HOLD);
    out_last  = (state == CV_HOLD) & last_byte;
    out_byte  = acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trit_cnt <= '0;
      slot     <= 3'd0;
      byte_cnt <= '0;
      col      <= 10'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_trit <= 1'b0;
    end else if (take_start) begin
      trit_cnt <= '0;
      slot     <= 3'd0;
      byte_cnt <= '0;
      col      <= 10'd0;
      busy     <= 1'b1;
      done     <= 1'b0;
      err_trit <= 1'b0;
    end else begin
      done <= 1'b0;
      if (copy) begin
        slot <= 3'd0;
        col  <= 10'd0;
      end else if (take_trit) begin
        for (int i = 0; i < 5; i++)
          if (slot == 3'(i)) col[2*i +: 2] <= tv;
        slot     <= slot + 3'd1;
        trit_cnt <= trit_cnt + CW'(1);
        if (in_trit == TRIT_ILL) err_trit <= 1'b1;
      end
      if (hs) begin
        byte_cnt <= byte_cnt + BW'(1);
        if (last_byte) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  trit5_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .copy      (copy),
    .grp       (col),
    .load      (acc_load),
    .add       (acc_add),
    .acc       (acc),
    .last_step (last_step)
  );

endmodule

// File: tb/tb_pack_s3_ctrl.sv
// Bench for pack_s3_ctrl: three instances (N=5, 7, 700),
// a queue-based packing model and a per-cycle compare process.
module tb_pack_s3_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_trit = 2'd0;

  wire [2:0] busy, done, in_ready, out_valid, out_last, err_trit;
  wire [7:0] ob0, ob1, ob2;

  logic [1:0] sel = 2'd0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic c_busy, c_done, c_in_ready, c_ov, c_ol, c_err;
  logic [7:0] c_ob;

  always #5 clk = ~clk;

  pack_s3_ctrl #(.N_COEFF(5)) u5 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]),
    .done(done[0]), .in_valid(in_valid), .in_trit(in_trit),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_byte(ob0), .out_last(out_last[0]),
    .out_ready(out_ready), .err_trit(err_trit[0]));

  pack_s3_ctrl #(.N_COEFF(7)) u7 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]),
    .done(done[1]), .in_valid(in_valid), .in_trit(in_trit),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_byte(ob1), .out_last(out_last[1]),
    .out_ready(out_ready), .err_trit(err_trit[1]));

  pack_s3_ctrl #(.N_COEFF(700)) u700 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[2]),
    .done(done[2]), .in_valid(in_valid), .in_trit(in_trit),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]),
    .out_byte(ob2), .out_last(out_last[2]),
    .out_ready(out_ready), .err_trit(err_trit[2]));

  always_comb begin
    c_busy = busy[0]; c_done = done[0]; c_in_ready = in_ready[0];
    c_ov = out_valid[0]; c_ol = out_last[0]; c_err = err_trit[0];
    c_ob = ob0;
    case (sel)
      2'd1: begin
        c_busy = busy[1]; c_done = done[1]; c_in_ready = in_ready[1];
        c_ov = out_valid[1]; c_ol = out_last[1]; c_err = err_trit[1];
        c_ob = ob1;
      end
      2'd2: begin
        c_busy = busy[2]; c_done = done[2]; c_in_ready = in_ready[2];
        c_ov = out_valid[2]; c_ol = out_last[2]; c_err = err_trit[2];
        c_ob = ob2;
      end
      default: ;
    endcase
  end

  function automatic int n_of(input logic [1:0] s);
    return (s == 2'd0) ? 5 : (s == 2'd1) ? 7 : 700;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Behavioural model state
  int  m_tcnt, gfill, bidx, t_first, gap_prev;
  bit  m_busy, m_done, m_err, prev_ov, prev_hs, prev_l;
  bit  chk_gap, stop_feed, rnd_ready, feed_on;
  logic [7:0] prev_b;
  int  grp [5];
  int  expq[$];
  int  got[$];
  int  q[$];

  task automatic model_clear();
    m_tcnt = 0; gfill = 0; bidx = 0; t_first = -100;
    expq.delete();
    for (int i = 0; i < 5; i++) grp[i] = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin : compare
    int n, nb, v, s, p;
    bit nbusy, nd;
    gap_prev = -1;
    model_clear();
    forever begin
      @(negedge clk);
      n = n_of(sel);
      nb = (n + 4) / 5;
      if (rst) begin
        chk("reset_outputs",
            int'({c_busy, c_done, c_in_ready, c_ov, c_ol, c_err, c_ob}), 0);
        m_busy = 0; m_done = 0; m_err = 0;
        prev_ov = 0; prev_hs = 0;
        model_clear();
        continue;
      end
      chk("busy", int'(c_busy), int'(m_busy));
      chk("done", int'(c_done), int'(m_done));
      chk("err_trit", int'(c_err), int'(m_err));
      if (!m_busy || m_tcnt == n)
        chk("in_ready_low", int'(c_in_ready), 0);
      if (c_ov && !m_busy)
        chk("out_valid_idle", int'(c_ov), 0);
      if (prev_ov && !prev_hs) begin
        chk("hold_valid", int'(c_ov), 1);
        chk("hold_byte", int'(c_ob), int'(prev_b));
        chk("hold_last", int'(c_ol), int'(prev_l));
      end
      if (c_ov && !prev_ov && bidx == 0)
        chk("first_latency", cyc, t_first + 6);
      nbusy = m_busy;
      nd = 0;
      if (c_ov && out_ready) begin
        if (expq.size() == 0) chk("byte_queue", expq.size(), 1);
        else chk("byte", int'(c_ob), expq.pop_front());
        chk("last", int'(c_ol), int'(bidx == nb - 1));
        if (chk_gap && gap_prev >= 0)
          chk("byte_gap", cyc - gap_prev, 6);
        gap_prev = cyc;
        got.push_back(int'(c_ob));
        bidx++;
        if (bidx == nb) begin
          nbusy = 0;
          nd = 1;
        end
      end
      if (!chk_gap) gap_prev = -1;
      if (start && !m_busy) begin
        nbusy = 1;
        m_err = 0;
        model_clear();
      end
      if (in_valid && c_in_ready) begin
        v = int'(in_trit);
        if (v == 3) begin
          m_err = 1;
          v = 0;
        end
        grp[gfill] = v;
        gfill++;
        m_tcnt++;
        if (gfill == 5 || m_tcnt == n) begin
          s = 0; p = 1;
          for (int i = 0; i < 5; i++) begin
            s += grp[i] * p;
            p *= 3;
            grp[i] = 0;
          end
          expq.push_back(s);
          if (m_tcnt <= 5) t_first = cyc + 1;
          gfill = 0;
        end
      end
      prev_ov = c_ov; prev_b = c_ob; prev_l = c_ol;
      prev_hs = c_ov && out_ready;
      m_busy = nbusy;
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int vals[$], input int pv, input int maxc);
    int i, c;
    bit a;
    i = 0; c = 0;
    while (i < vals.size() && c < maxc && !stop_feed) begin
      in_valid = ($urandom_range(0, 99) < pv);
      in_trit = 2'(vals[i]);
      @(negedge clk);
      a = in_valid && c_in_ready;
      tick();
      if (a) i++;
      c++;
    end
    in_valid = 1'b0;
    if (i < vals.size() && !stop_feed)
      chk("feed_timeout", i, vals.size());
  endtask

  task automatic wait_done(input int maxc);
    int c;
    bit seen;
    c = 0; seen = 0;
    while (c < maxc) begin
      @(negedge clk);
      if (c_done) begin
        seen = 1;
        break;
      end
      c++;
    end
    chk("done_seen", int'(seen), 1);
    tick();
  endtask

  task automatic run_group(input int vals[$], input int exp_b[$]);
    do_reset();
    got.delete();
    out_ready = 1'b1;
    pulse_start();
    feed(vals, 100, 200);
    wait_done(100);
    chk("group_nbytes", got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++)
      chk("golden_byte", got[i], exp_b[i]);
  endtask

  initial begin : stim
    int c;
    do_reset();

    sel = 2'd0;
    run_group({1, 0, 0, 0, 0}, {1});
    run_group({0, 0, 0, 0, 2}, {162});
    run_group({2, 2, 2, 2, 2}, {242});
    run_group({1, 2, 0, 1, 2}, {196});

    sel = 2'd1;
    run_group({1, 1, 1, 1, 1, 1, 1}, {121, 4});

    sel = 2'd0;
    run_group({1, 1, 3, 0, 0}, {4});
    chk("err_sticky", int'(c_err), 1);
    repeat (5) tick();
    chk("err_sticky_late", int'(c_err), 1);
    pulse_start();
    chk("err_cleared", int'(c_err), 0);

    do_reset();
    got.delete();
    pulse_start();
    feed({1, 1, 1, 1, 1}, 100, 50);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #10 rst = 1'b0;
    tick();
    repeat (10) tick();
    chk("abort_no_byte", got.size(), 0);
    chk("abort_idle", int'(c_busy), 0);
    pulse_start();
    feed({0, 1, 0, 0, 0}, 100, 50);
    wait_done(50);
    chk("after_abort_nbytes", got.size(), 1);
    if (got.size() > 0) chk("after_abort_byte", got[0], 3);

    sel = 2'd2;
    do_reset();
    got.delete();
    out_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 700; i++) q.push_back(int'($urandom_range(0, 2)));
    chk_gap = 1'b1;
    pulse_start();
    feed(q, 100, 3000);
    wait_done(200);
    chk_gap = 1'b0;
    chk("stream_nbytes", got.size(), 140);
    chk("stream_trits", m_tcnt, 700);
    chk("stream_in_ready_off", int'(c_in_ready), 0);

    do_reset();
    got.delete();
    out_ready = 1'b0;
    stop_feed = 1'b0;
    pulse_start();
    fork
      feed(q, 100, 5000);
    join_none
    c = 0;
    while (!c_ov && c < 50) begin
      tick();
      c++;
    end
    chk("bp_valid_rise", int'(c_ov), 1);
    repeat (20) tick();
    chk("bp_in_ready_low", int'(c_in_ready), 0);
    chk("bp_trits", m_tcnt, 10);
    chk_gap = 1'b1;
    out_ready = 1'b1;
    c = 0;
    while (bidx < 4 && c < 100) begin
      tick();
      c++;
    end
    chk("bp_bytes", got.size(), 4);
    chk_gap = 1'b0;
    stop_feed = 1'b1;
    repeat (3) tick();
    do_reset();
    stop_feed = 1'b0;

    do_reset();
    got.delete();
    q.delete();
    for (int i = 0; i < 700; i++)
      q.push_back(($urandom_range(0, 19) == 0) ? 3
                  : int'($urandom_range(0, 2)));
    rnd_ready = 1'b1;
    pulse_start();
    feed_on = 1'b1;
    fork
      begin
        feed(q, 70, 8000);
        feed_on = 1'b0;
      end
    join_none
    repeat (40) tick();
    pulse_start();
    c = 0;
    while (feed_on && c < 9000) begin
      tick();
      c++;
    end
    chk("rnd_feed_end", int'(feed_on), 0);
    wait_done(3000);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    chk("rnd_nbytes", got.size(), 140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
